audio_i2s_tx: RTL and testbench

Stereo audio output serializer that drains the left and right audio output FIFOs of `fm_radio_top` and transmits each sample pair as one 16-bit-per-channel I2S frame. It is the consumer end of the `*_audio_out_empty` / `*_audio_out_rd_en` / `*_audio_out_data` interface that the radio core writes. Samples are popped in lock-step pairs, saturated to the PCM width, and shifted out MSB-first. If the FIFOs starve, zero frames keep the bit clock running and a counter records the underflow.

---
 rtl/audio_i2s_tx.sv | 161 ++++++++++++++++
 tb/tb_audio_i2s_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_tx
//  Description : Stereo I2S serializer. Drains the left/right audio FIFOs in
//                lock-step pairs, saturates each word to SAMPLE_BITS and
//                shifts the frame out MSB-first with a one-slot I2S delay.
//                Starved FIFOs produce zero frames and bump underflow_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_i2s_tx #(
    parameter int DATA_SIZE   = 32,
    parameter int SAMPLE_BITS = 16,
    parameter int CLK_DIV     = 4    // system clocks per sclk half-period, >= 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 left_audio_out_empty,
    input  logic                 right_audio_out_empty,
    input  logic [DATA_SIZE-1:0] left_audio_out_data,
    input  logic [DATA_SIZE-1:0] right_audio_out_data,
    output logic                 left_audio_out_rd_en,
    output logic                 right_audio_out_rd_en,
    output logic                 i2s_sclk,
    output logic                 i2s_lrclk,
    output logic                 i2s_sdata,
    output logic [15:0]          underflow_count
);

    localparam int c_frame_bits = 2 * SAMPLE_BITS;
    localparam int c_slot_w     = $clog2(c_frame_bits);
    localparam int c_div_w      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_slot_w-1:0] c_last_slot  = c_slot_w'(c_frame_bits - 1);
    localparam logic [c_slot_w-1:0] c_left_slots = c_slot_w'(SAMPLE_BITS);
    localparam logic [c_div_w-1:0]  c_div_last   = c_div_w'(CLK_DIV - 1);

    // Signed PCM limits expressed at the FIFO word width.
    localparam logic signed [DATA_SIZE-1:0] c_sat_max =
        {{(DATA_SIZE-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
    localparam logic signed [DATA_SIZE-1:0] c_sat_min =
        {{(DATA_SIZE-SAMPLE_BITS+1){1'b1}}, {(SAMPLE_BITS-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [c_div_w-1:0]      r_div;
    logic [c_slot_w-1:0]     r_slot;
    logic [c_frame_bits-1:0] r_frame;
    logic                    r_sclk;
    logic                    r_lrclk;
    logic                    r_sdata;
    logic [15:0]             r_underflow;

    logic                    w_both_ready;
    logic                    w_sclk_fall;
    logic                    w_frame_end;
    logic                    w_pop;
    logic [c_slot_w-1:0]     w_next_slot;
    logic [c_slot_w-1:0]     w_bit_idx;
    logic [c_frame_bits-1:0] w_frame_next;

    function automatic logic [SAMPLE_BITS-1:0] sat(input logic signed [DATA_SIZE-1:0] x);
        if (x > c_sat_max) begin
            return c_sat_max[SAMPLE_BITS-1:0];
        end else if (x < c_sat_min) begin
            return c_sat_min[SAMPLE_BITS-1:0];
        end else begin
            return x[SAMPLE_BITS-1:0];
        end
    endfunction

    assign w_both_ready = ~left_audio_out_empty & ~right_audio_out_empty;
    // The next edge drops sclk; at the last slot that edge opens a new frame.
    assign w_sclk_fall  = (r_state == ST_RUN) && (r_div == c_div_last) && r_sclk;
    assign w_frame_end  = w_sclk_fall && (r_slot == c_last_slot);
    // A pair is only ever popped together, and only where a frame may start.
    assign w_pop        = ~reset & enable & w_both_ready &
                          ((r_state == ST_IDLE) | w_frame_end);
    assign w_next_slot  = r_slot + 1'b1;
    // Slot k carries F[2*SAMPLE_BITS-k]; entering slot s+1 selects F[last-s].
    assign w_bit_idx    = c_last_slot - r_slot;
    assign w_frame_next = {sat(left_audio_out_data), sat(right_audio_out_data)};

    // Frame sequencer: bit-clock divider, slot counter and shift outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_div       <= '0;
            r_slot      <= '0;
            r_frame     <= '0;
            r_sclk      <= 1'b0;
            r_lrclk     <= 1'b0;
            r_sdata     <= 1'b0;
            r_underflow <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_RUN;
                        r_frame <= w_frame_next;
                        r_div   <= '0;
                        r_slot  <= '0;
                        r_sclk  <= 1'b0;
                        r_lrclk <= 1'b0;
                        r_sdata <= 1'b0;    // no retained bit after idle
                    end
                end
                ST_RUN: begin
                    if (r_div == c_div_last) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end

                    if (w_frame_end) begin
                        if (!enable) begin
                            r_state <= ST_IDLE;
                            r_frame <= '0;
                            r_div   <= '0;
                            r_slot  <= '0;
                            r_sclk  <= 1'b0;
                            r_lrclk <= 1'b0;
                            r_sdata <= 1'b0;
                        end else begin
                            r_slot  <= '0;
                            r_lrclk <= 1'b0;
                            r_sdata <= r_frame[0];   // previous right LSB
                            if (w_both_ready) begin
                                r_frame <= w_frame_next;
                            end else begin
                                r_frame <= '0;
                                if (r_underflow != 16'hFFFF) begin
                                    r_underflow <= r_underflow + 16'd1;
                                end
                            end
                        end
                    end else if (w_sclk_fall) begin
                        r_slot  <= w_next_slot;
                        r_lrclk <= (w_next_slot >= c_left_slots);
                        r_sdata <= r_frame[w_bit_idx];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign left_audio_out_rd_en  = w_pop;
    assign right_audio_out_rd_en = w_pop;
    assign i2s_sclk              = r_sclk;
    assign i2s_lrclk             = r_lrclk;
    assign i2s_sdata             = r_sdata;
    assign underflow_count       = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_i2s_tx
//  Description : Self-checking bench for audio_i2s_tx. FIFOs are modelled as
//                queues; a frame-timeline model predicts every output on
//                every cycle, and captured serial words are pinned to
//                hand-computed literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_tx;

    localparam int CD     = 4;
    localparam int SB     = 16;
    localparam int PERIOD = 4 * SB * CD;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        left_audio_out_empty = 1'b1;
    logic        right_audio_out_empty = 1'b1;
    logic [31:0] left_audio_out_data = '0;
    logic [31:0] right_audio_out_data = '0;
    logic        left_audio_out_rd_en;
    logic        right_audio_out_rd_en;
    logic        i2s_sclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic [15:0] underflow_count;

    audio_i2s_tx #(.DATA_SIZE(32), .SAMPLE_BITS(SB), .CLK_DIV(CD)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .enable                (enable),
        .left_audio_out_empty  (left_audio_out_empty),
        .right_audio_out_empty (right_audio_out_empty),
        .left_audio_out_data   (left_audio_out_data),
        .right_audio_out_data  (right_audio_out_data),
        .left_audio_out_rd_en  (left_audio_out_rd_en),
        .right_audio_out_rd_en (right_audio_out_rd_en),
        .i2s_sclk              (i2s_sclk),
        .i2s_lrclk             (i2s_lrclk),
        .i2s_sdata             (i2s_sdata),
        .underflow_count       (underflow_count)
    );

    always #5 clock = ~clock;

    // Environment FIFOs and bookkeeping.
    logic [31:0] lq[$];
    logic [31:0] rq[$];
    logic [31:0] cap_q[$];
    int          pop_times[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic        pl = 1'b0;
    logic        pr = 1'b0;

    // Model state: frame timeline position and content.
    logic        m_run = 1'b0;
    int          m_t   = 0;
    logic [31:0] m_frame = '0;
    logic        m_ret = 1'b0;
    logic [15:0] m_uf  = '0;
    logic [31:0] cap_word = '0;
    logic        cap_open = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [31:0] x);
        int v;
        v = int'(x);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return x[15:0];
    endfunction

    task automatic drive_fifo();
        left_audio_out_empty  = (lq.size() == 0);
        right_audio_out_empty = (rq.size() == 0);
        left_audio_out_data   = '0;
        right_audio_out_data  = '0;
        if (lq.size() > 0) left_audio_out_data = lq[0];
        if (rq.size() > 0) right_audio_out_data = rq[0];
    endtask

    function automatic logic [31:0] cap_at(input int i);
        if (i < cap_q.size()) return cap_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Per-cycle compare against the timeline model, then advance the model.
    always @(negedge clock) begin : p_compare
        int   slot;
        logic e_sclk, e_lr, e_sd, e_pop, both;
        e_sclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0; slot = 0;
        if (m_run) begin
            slot   = m_t / (2 * CD);
            e_sclk = ((m_t / CD) % 2) == 1;
            e_lr   = (slot >= SB);
            e_sd   = (slot == 0) ? m_ret : m_frame[32 - slot];
            if ((m_t % (2 * CD)) == CD) begin
                if (slot == 0) begin
                    if (cap_open) begin
                        cap_word[0] = i2s_sdata;
                        cap_q.push_back(cap_word);
                        cap_open = 1'b0;
                    end
                end else begin
                    cap_word[32 - slot] = i2s_sdata;
                    if (slot == 1) cap_open = 1'b1;
                end
            end
        end
        chk("sclk",  {31'd0, i2s_sclk},  {31'd0, e_sclk});
        chk("lrclk", {31'd0, i2s_lrclk}, {31'd0, e_lr});
        chk("sdata", {31'd0, i2s_sdata}, {31'd0, e_sd});
        chk("underflow", {16'd0, underflow_count}, {16'd0, m_uf});

        both  = (lq.size() > 0) && (rq.size() > 0);
        e_pop = 1'b0;
        if (reset) begin
            m_run = 1'b0; m_t = 0; m_frame = '0; m_ret = 1'b0; m_uf = '0;
            cap_open = 1'b0;
        end else if (!m_run) begin
            if (enable && both) begin
                e_pop = 1'b1;
                m_run = 1'b1; m_t = 0; m_ret = 1'b0;
                m_frame = {sat16(lq[0]), sat16(rq[0])};
            end
        end else if (m_t == PERIOD - 1) begin
            m_ret = m_frame[0];
            m_t   = 0;
            if (!enable) begin
                m_run = 1'b0; m_frame = '0; cap_open = 1'b0;
            end else if (both) begin
                e_pop   = 1'b1;
                m_frame = {sat16(lq[0]), sat16(rq[0])};
            end else begin
                m_frame = '0;
                if (m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
            end
        end else begin
            m_t++;
        end
        chk("rd_en_left",  {31'd0, left_audio_out_rd_en},  {31'd0, e_pop});
        chk("rd_en_right", {31'd0, right_audio_out_rd_en}, {31'd0, e_pop});
        if (left_audio_out_rd_en) pop_times.push_back(cyc);
        pl = left_audio_out_rd_en;
        pr = right_audio_out_rd_en;
        cyc++;
    end

    // One clock: FIFOs honour the pops seen before the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (pl && lq.size() > 0) void'(lq.pop_front());
        if (pr && rq.size() > 0) void'(rq.pop_front());
        drive_fifo();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
        lq.push_back(l);
        rq.push_back(r);
        drive_fifo();
    endtask

    task automatic wait_t(input int target, input string name);
        int n;
        n = 0;
        while (!(m_run && m_t == target) && n < 600) begin
            tick();
            n++;
        end
        chk(name, {31'd0, (m_run && m_t == target)}, 32'd1);
    endtask

    initial begin
        int n;
        // Reset held two cycles with data waiting.
        push_pair(32'h0000_1234, 32'hFFFF_FFFE);
        reset  = 1'b1;
        enable = 1'b1;
        run(2);
        chk("rst_sclk",  {31'd0, i2s_sclk},  32'd0);
        chk("rst_lrclk", {31'd0, i2s_lrclk}, 32'd0);
        chk("rst_sdata", {31'd0, i2s_sdata}, 32'd0);
        chk("rst_rden",  {31'd0, left_audio_out_rd_en | right_audio_out_rd_en}, 32'd0);
        chk("rst_uf",    {16'd0, underflow_count}, 32'd0);
        chk("rst_fifo_kept", lq.size(), 32'd1);
        reset = 1'b0;

        // Single pair, then a starved zero frame.
        run(300);
        chk("single_word", cap_at(0), 32'h1234_FFFE);
        chk("single_uf",   {16'd0, underflow_count}, 32'd1);

        // Saturation pair.
        push_pair(32'h0001_2345, 32'hFFFE_0000);
        run(256);
        chk("zero_frame", cap_at(1), 32'h0000_0000);

        // Back-to-back pairs.
        push_pair(32'h0000_0001, 32'hFFFF_8000);
        push_pair(32'h0000_7FFF, 32'h8000_0000);
        push_pair(32'hFFFF_FFFF, 32'h0000_5555);
        push_pair(32'h0000_AAAA, 32'hFFFF_7FFF);
        run(1145);
        chk("sat_word", cap_at(2), 32'h7FFF_8000);
        chk("b2b_w0",   cap_at(3), 32'h0001_8000);
        chk("b2b_w1",   cap_at(4), 32'h7FFF_8000);
        chk("b2b_w2",   cap_at(5), 32'hFFFF_5555);
        chk("b2b_uf",   {16'd0, underflow_count}, 32'd1);
        chk("pop_count", pop_times.size(), 32'd6);
        if (pop_times.size() >= 6) begin
            chk("gap_underflow", pop_times[1] - pop_times[0], 32'd512);
            for (int i = 2; i < 6; i++)
                chk("gap_b2b", pop_times[i] - pop_times[i-1], 32'd256);
        end

        // One-sided empty at a boundary.
        lq.push_back(32'h0000_0ABC);
        drive_fifo();
        run(200);
        chk("b2b_w3",      cap_at(6), 32'h7FFF_8000);
        chk("os_uf",       {16'd0, underflow_count}, 32'd2);
        chk("os_left_sz",  lq.size(), 32'd1);
        chk("os_left_hd",  (lq.size() > 0) ? lq[0] : 32'h0, 32'h0000_0ABC);
        chk("os_pops",     pop_times.size(), 32'd6);
        rq.push_back(32'h0000_0DEF);
        drive_fifo();
        run(150);
        chk("os_pair_popped", pop_times.size(), 32'd7);

        // Drop enable at slot 5: frame completes, then idle.
        wait_t(40, "wait_slot5");
        chk("os_zero_frame", cap_at(7), 32'h0000_0000);
        enable = 1'b0;
        push_pair(32'h0000_0055, 32'h0000_0066);
        n = 0;
        while (m_run && n < 400) begin
            tick();
            n++;
        end
        chk("idle_reached", {31'd0, m_run}, 32'd0);
        chk("idle_sclk",    {31'd0, i2s_sclk}, 32'd0);
        run(20);
        chk("idle_no_pop",  lq.size(), 32'd1);
        chk("idle_pops",    pop_times.size(), 32'd7);

        // Restart, then reset at slot 20.
        enable = 1'b1;
        wait_t(160, "wait_slot20");
        chk("restart_popped", lq.size(), 32'd0);
        reset = 1'b1;
        tick();
        chk("mid_rst_sclk",  {31'd0, i2s_sclk},  32'd0);
        chk("mid_rst_lrclk", {31'd0, i2s_lrclk}, 32'd0);
        chk("mid_rst_sdata", {31'd0, i2s_sdata}, 32'd0);
        chk("mid_rst_uf",    {16'd0, underflow_count}, 32'd0);
        reset  = 1'b0;
        enable = 1'b0;
        run(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
